regs_mt: RTL and testbench
==========================

Name: regs_mt

Overview:
Parametrised successor to the io881 per-thread register file. Holds A/B data registers, PC and two pointer registers per thread, plus mempage, CSB and two pointer registers per channel. Widths and thread/channel counts are configurable. Adds three things the previous generation lacked: a hardware clear sequencer after reset, optional same-cycle write-to-read forwarding, and an in-place pointer increment port. Sits between the thread scheduler and the execute stage.

Parameters:
THREADS, 32, number of hardware threads (power of 2, ≥2)
CHANS, 16, number of I/O channels (power of 2, ≥2)
DW, 8, data register width (A, B, CSB, mempage)
AW, 12, address width (PC, pointers)
BYPASS, 1, 1 = forward same-cycle writes to matching reads; 0 = reads show stored value only

Ports:
clk  in  1  clock; all writes sampled on posedge
rst  in  1  asynchronous, active-high reset
rthreadid  in  log2(THREADS)  read thread select
rchanid  in  log2(CHANS)  read channel select
psel0, psel1  in  2  pointer select for qp0/qp1 (0=P0 thread, 1=P1 thread, 2=P2 chan, 3=P3 chan)
qa, qb  out  DW  A/B of rthreadid
qp0, qp1  out  AW  selected pointers
qpc  out  AW  PC of rthreadid
qcsb, qmempage  out  DW  CSB/mempage of rchanid
wthreadid  in  log2(THREADS)  write thread select
wchanid  in  log2(CHANS)  write channel select
d8  in  DW  data for A, B, CSB, mempage
wea, web, wecsb, wemempage  in  1  write enables, d8 bus
d12  in  AW  pointer write data
pselw  in  2  pointer write select
wep  in  1  pointer write enable
incp  in  1  increment pointer incsel at wthreadid/wchanid
incsel  in  2  pointer increment select
dpc  in  AW  PC write data
wepc  in  1  PC write enable
init_busy  out  1  high while reset or clear sequence is active

Behaviour:
- Reads are combinational from the ids and psel. There are no modelled delays.
- Writes take effect at posedge. The stored value is visible on the next cycle.
- Every enable is independent. All may fire in the same cycle.
- Pointer index: P0/P1 use wthreadid; P2/P3 use wchanid.
- Increment:
  - target = target + 1 mod 2^AW, e.g. 0xFFF → 0x000 when AW=12.
  - If wep and incp select the same pointer, wep wins and d12 is stored.
  - If they select different pointers, both are performed.
- BYPASS=1:
  - Any read whose array and index match an active write this cycle returns the value being written: d8, d12, dpc, or the incremented value.
  - A qp0/qp1 read of P2/P3 matches on rchanid==wchanid. A read of P0/P1 matches on rthreadid==wthreadid.
- BYPASS=0: reads always return the stored contents.
- State machine CLEAR → RUN:
  - While rst is high: state=CLEAR, idx=0, init_busy=1.
  - CLEAR: each cycle, zero entry idx of every array for which idx is in range, then idx++.
  - CLEAR lasts max(THREADS, CHANS) cycles, then moves to RUN and init_busy=0 on the same edge.
  - In CLEAR, all write and increment enables are ignored, and all q outputs are forced to 0.
- Reset output values: all q outputs=0, init_busy=1.
- Reset asserted mid-operation restarts CLEAR at idx 0. Partially written contents are not guaranteed, but CLEAR overwrites them.
- After CLEAR completes, every register reads 0.

Decomposition:
- Shared package regs_mt_pkg holds:
  - PSEL_P0..PSEL_P3 encodings
  - state enum {ST_CLEAR, ST_RUN}
  - a function for the clear length max(THREADS, CHANS)
- One sub-module regs_mt_bank(DEPTH, WIDTH): a single-write, multi-read array with a clear port and optional bypass. It is instantiated once per register class: A, B, PC, P0, P1, P2, P3, CSB, mempage.

Test Plan:
- Reset then release: init_busy stays 1 for exactly 32 cycles (default parameters). Then all reads are 0. A wea write during CLEAR is discarded (qa=0 afterwards).
- After CLEAR: wea, thread 5, d8=0xA5, with rthreadid=5, BYPASS=1 → qa=0xA5 in the same cycle. With BYPASS=0 → qa=0x00 in that cycle and 0xA5 the next.
- P2 of channel 3 = 0xFFF, then incp with incsel=2, wchanid=3 → qp0 (psel0=2, rchanid=3) reads 0x000 next cycle. Thread-indexed P0 is unchanged.
- Same cycle: wep with pselw=1, d12=0x123, plus incp with incsel=1, thread 7 (P1 previously 0x010) → P1=0x123. Repeat with incsel=0: P0 is incremented and P1=0x123.
- All enables fire in one cycle with distinct data → every array is updated and reads back correctly. Checked at THREADS=8, CHANS=4, DW=16, AW=16; CLEAR lasts 8 cycles.
- Assert rst mid-traffic, release, then run CLEAR → every location reads 0. init_busy is high throughout reset and CLEAR.

Source files
------------

// File: rtl/regs_mt_pkg.sv
// Shared definitions for the multi-thread register file.
//   PSEL_P0..PSEL_P3 : pointer select encodings (P0/P1 thread-indexed, P2/P3 channel-indexed)
//   state_t          : clear sequencer states
//   clear_len()      : number of cycles the post-reset clear takes
package regs_mt_pkg;

    localparam logic [1:0] PSEL_P0 = 2'd0;
    localparam logic [1:0] PSEL_P1 = 2'd1;
    localparam logic [1:0] PSEL_P2 = 2'd2;
    localparam logic [1:0] PSEL_P3 = 2'd3;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // The clear walks the deeper of the two index spaces.
    function automatic int clear_len(input int threads, input int chans);
        int len;
        if (threads > chans) begin
            len = threads;
        end else begin
            len = chans;
        end
        return len;
    endfunction

endpackage

// File: rtl/regs_mt_bank.sv
// One register class (e.g. all A registers): DEPTH entries of WIDTH bits.
// Ports:
//   clk          : clock
//   clr, caddr   : zero entry caddr this cycle (takes priority over writes)
//   we, waddr,
//   wdata        : write wdata to entry waddr
//   inc          : increment entry waddr in place (we wins when both set)
//   raddr, q     : combinational read; with BYPASS!=0 a same-cycle write to
//                  raddr is forwarded onto q
module regs_mt_bank
    import regs_mt_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int WIDTH  = 8,
    parameter int BYPASS = 1
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic [$clog2(DEPTH)-1:0] caddr,
    input  logic                     we,
    input  logic                     inc,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         q
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic             wen_s;
    logic [WIDTH-1:0] wval_s;

    // Value committed this cycle: explicit data beats the increment.
    always_comb begin
        wen_s = we | inc;
        if (we) begin
            wval_s = wdata;
        end else begin
            wval_s = mem[waddr] + ONE;
        end
    end

    // Read port with optional write forwarding.
    always_comb begin
        if ((BYPASS != 0) && wen_s && (raddr == waddr)) begin
            q = wval_s;
        end else begin
            q = mem[raddr];
        end
    end

    // Storage update; the clear sequencer owns the array while clr is high.
    always_ff @(posedge clk) begin
        if (clr) begin
            mem[caddr] <= {WIDTH{1'b0}};
        end else if (wen_s) begin
            mem[waddr] <= wval_s;
        end
    end

endmodule

// File: rtl/regs_mt.sv
// Per-thread / per-channel register file between scheduler and execute stage.
// Thread arrays: A, B (DW), PC, P0, P1 (AW). Channel arrays: CSB, mempage (DW), P2, P3 (AW).
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   rthreadid, rchanid,
//   psel0, psel1              : read selects
//   qa, qb, qpc, qp0, qp1,
//   qcsb, qmempage            : combinational read data (0 while clearing)
//   wthreadid, wchanid        : write indices
//   d8 + wea/web/wecsb/wemempage, d12 + pselw/wep, incp/incsel, dpc/wepc : writes
//   init_busy                 : high during reset and the clear sequence
module regs_mt
    import regs_mt_pkg::*;
#(
    parameter int THREADS = 32,
    parameter int CHANS   = 16,
    parameter int DW      = 8,
    parameter int AW      = 12,
    parameter int BYPASS  = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [$clog2(THREADS)-1:0] rthreadid,
    input  logic [$clog2(CHANS)-1:0]   rchanid,
    input  logic [1:0]                 psel0,
    input  logic [1:0]                 psel1,
    output logic [DW-1:0]              qa,
    output logic [DW-1:0]              qb,
    output logic [AW-1:0]              qp0,
    output logic [AW-1:0]              qp1,
    output logic [AW-1:0]              qpc,
    output logic [DW-1:0]              qcsb,
    output logic [DW-1:0]              qmempage,
    input  logic [$clog2(THREADS)-1:0] wthreadid,
    input  logic [$clog2(CHANS)-1:0]   wchanid,
    input  logic [DW-1:0]              d8,
    input  logic                       wea,
    input  logic                       web,
    input  logic                       wecsb,
    input  logic                       wemempage,
    input  logic [AW-1:0]              d12,
    input  logic [1:0]                 pselw,
    input  logic                       wep,
    input  logic                       incp,
    input  logic [1:0]                 incsel,
    input  logic [AW-1:0]              dpc,
    input  logic                       wepc,
    output logic                       init_busy
);

    localparam int TW      = $clog2(THREADS);
    localparam int CW      = $clog2(CHANS);
    localparam int CLR_LEN = clear_len(THREADS, CHANS);
    localparam int IW      = $clog2(CLR_LEN);
    localparam logic [IW-1:0] IDX_LAST = IW'(CLR_LEN - 1);
    localparam logic [IW-1:0] IDX_ONE  = {{(IW-1){1'b0}}, 1'b1};

    state_t        state_r;
    logic [IW-1:0] idx_r;
    logic          init_busy_r;
    logic          run_s, clr_t_s, clr_c_s;
    logic [3:0]    p_we_s, p_inc_s;
    logic [DW-1:0] a_q_s, b_q_s, csb_q_s, mp_q_s;
    logic [AW-1:0] pc_q_s, p0_q_s, p1_q_s, p2_q_s, p3_q_s;

    // Picks one of the four pointer read values.
    function automatic logic [AW-1:0] sel_ptr(input logic [1:0] s, input logic [AW-1:0] v0,
                                              input logic [AW-1:0] v1, input logic [AW-1:0] v2,
                                              input logic [AW-1:0] v3);
        logic [AW-1:0] r;
        case (s)
            PSEL_P0: r = v0;
            PSEL_P1: r = v1;
            PSEL_P2: r = v2;
            PSEL_P3: r = v3;
            default: r = {AW{1'b0}};
        endcase
        return r;
    endfunction

    // Clear sequencer: one entry of every array per cycle, then RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_CLEAR;
            idx_r       <= {IW{1'b0}};
            init_busy_r <= 1'b1;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    if (idx_r == IDX_LAST) begin
                        state_r     <= ST_RUN;
                        idx_r       <= {IW{1'b0}};
                        init_busy_r <= 1'b0;
                    end else begin
                        idx_r <= idx_r + IDX_ONE;
                    end
                end
                ST_RUN: begin
                    init_busy_r <= 1'b0;
                end
                default: begin
                    state_r     <= ST_CLEAR;
                    idx_r       <= {IW{1'b0}};
                    init_busy_r <= 1'b1;
                end
            endcase
        end
    end

    assign init_busy = init_busy_r;

    // Clear only the arrays deep enough to hold the current index.
    always_comb begin
        run_s   = (state_r == ST_RUN);
        clr_t_s = !run_s && (32'(idx_r) < 32'(THREADS));
        clr_c_s = !run_s && (32'(idx_r) < 32'(CHANS));
    end

    // Decode pointer write / increment targets; nothing fires while clearing.
    always_comb begin
        p_we_s  = 4'b0000;
        p_inc_s = 4'b0000;
        if (run_s) begin
            if (wep) begin
                p_we_s[pselw] = 1'b1;
            end else begin
                p_we_s = 4'b0000;
            end
            if (incp) begin
                p_inc_s[incsel] = 1'b1;
            end else begin
                p_inc_s = 4'b0000;
            end
        end else begin
            p_we_s  = 4'b0000;
            p_inc_s = 4'b0000;
        end
    end

    regs_mt_bank #(.DEPTH(THREADS), .WIDTH(DW), .BYPASS(BYPASS)) u_a (
        .clk(clk), .clr(clr_t_s), .caddr(idx_r[TW-1:0]), .we(run_s & wea), .inc(1'b0),
        .waddr(wthreadid), .wdata(d8), .raddr(rthreadid), .q(a_q_s));
    regs_mt_bank #(.DEPTH(THREADS), .WIDTH(DW), .BYPASS(BYPASS)) u_b (
        .clk(clk), .clr(clr_t_s), .caddr(idx_r[TW-1:0]), .we(run_s & web), .inc(1'b0),
        .waddr(wthreadid), .wdata(d8), .raddr(rthreadid), .q(b_q_s));
    regs_mt_bank #(.DEPTH(THREADS), .WIDTH(AW), .BYPASS(BYPASS)) u_pc (
        .clk(clk), .clr(clr_t_s), .caddr(idx_r[TW-1:0]), .we(run_s & wepc), .inc(1'b0),
        .waddr(wthreadid), .wdata(dpc), .raddr(rthreadid), .q(pc_q_s));
    regs_mt_bank #(.DEPTH(THREADS), .WIDTH(AW), .BYPASS(BYPASS)) u_p0 (
        .clk(clk), .clr(clr_t_s), .caddr(idx_r[TW-1:0]), .we(p_we_s[0]), .inc(p_inc_s[0]),
        .waddr(wthreadid), .wdata(d12), .raddr(rthreadid), .q(p0_q_s));
    regs_mt_bank #(.DEPTH(THREADS), .WIDTH(AW), .BYPASS(BYPASS)) u_p1 (
        .clk(clk), .clr(clr_t_s), .caddr(idx_r[TW-1:0]), .we(p_we_s[1]), .inc(p_inc_s[1]),
        .waddr(wthreadid), .wdata(d12), .raddr(rthreadid), .q(p1_q_s));
    regs_mt_bank #(.DEPTH(CHANS), .WIDTH(AW), .BYPASS(BYPASS)) u_p2 (
        .clk(clk), .clr(clr_c_s), .caddr(idx_r[CW-1:0]), .we(p_we_s[2]), .inc(p_inc_s[2]),
        .waddr(wchanid), .wdata(d12), .raddr(rchanid), .q(p2_q_s));
    regs_mt_bank #(.DEPTH(CHANS), .WIDTH(AW), .BYPASS(BYPASS)) u_p3 (
        .clk(clk), .clr(clr_c_s), .caddr(idx_r[CW-1:0]), .we(p_we_s[3]), .inc(p_inc_s[3]),
        .waddr(wchanid), .wdata(d12), .raddr(rchanid), .q(p3_q_s));
    regs_mt_bank #(.DEPTH(CHANS), .WIDTH(DW), .BYPASS(BYPASS)) u_csb (
        .clk(clk), .clr(clr_c_s), .caddr(idx_r[CW-1:0]), .we(run_s & wecsb), .inc(1'b0),
        .waddr(wchanid), .wdata(d8), .raddr(rchanid), .q(csb_q_s));
    regs_mt_bank #(.DEPTH(CHANS), .WIDTH(DW), .BYPASS(BYPASS)) u_mp (
        .clk(clk), .clr(clr_c_s), .caddr(idx_r[CW-1:0]), .we(run_s & wemempage), .inc(1'b0),
        .waddr(wchanid), .wdata(d8), .raddr(rchanid), .q(mp_q_s));

    // Read outputs; held at zero until the clear has finished.
    always_comb begin
        if (run_s) begin
            qa       = a_q_s;
            qb       = b_q_s;
            qpc      = pc_q_s;
            qcsb     = csb_q_s;
            qmempage = mp_q_s;
            qp0      = sel_ptr(psel0, p0_q_s, p1_q_s, p2_q_s, p3_q_s);
            qp1      = sel_ptr(psel1, p0_q_s, p1_q_s, p2_q_s, p3_q_s);
        end else begin
            qa       = {DW{1'b0}};
            qb       = {DW{1'b0}};
            qpc      = {AW{1'b0}};
            qcsb     = {DW{1'b0}};
            qmempage = {DW{1'b0}};
            qp0      = {AW{1'b0}};
            qp1      = {AW{1'b0}};
        end
    end

endmodule

// File: tb/tb_regs_mt.sv
// Bench for regs_mt: one default instance (BYPASS=1) and one small
// instance (THREADS=8, CHANS=4, DW=16, AW=16, BYPASS=0) sharing clk/rst.
module tb_regs_mt;

    logic clk, rst;

    // Instance A: default parameters
    logic [4:0]  a_rt, a_wt;
    logic [3:0]  a_rc, a_wc;
    logic [1:0]  a_ps0, a_ps1, a_pselw, a_incsel;
    logic [7:0]  a_qa, a_qb, a_qcsb, a_qmp, a_d8;
    logic [11:0] a_qp0, a_qp1, a_qpc, a_d12, a_dpc;
    logic        a_wea, a_web, a_wecsb, a_wemp, a_wep, a_incp, a_wepc, a_busy;

    // Instance B: small, no forwarding
    logic [2:0]  b_rt, b_wt;
    logic [1:0]  b_rc, b_wc;
    logic [1:0]  b_ps0, b_ps1, b_pselw, b_incsel;
    logic [15:0] b_qa, b_qb, b_qcsb, b_qmp, b_d8;
    logic [15:0] b_qp0, b_qp1, b_qpc, b_d12, b_dpc;
    logic        b_wea, b_web, b_wecsb, b_wemp, b_wep, b_incp, b_wepc, b_busy;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct { string name; logic [31:0] exp; } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic [4:0] wt; logic [4:0] rt; logic wea; logic web;
        logic [7:0] d8; logic [7:0] eqa; logic [7:0] eqb;
    } vec_t;
    vec_t vecs[7];

    regs_mt dut_a (
        .clk(clk), .rst(rst), .rthreadid(a_rt), .rchanid(a_rc), .psel0(a_ps0), .psel1(a_ps1),
        .qa(a_qa), .qb(a_qb), .qp0(a_qp0), .qp1(a_qp1), .qpc(a_qpc), .qcsb(a_qcsb),
        .qmempage(a_qmp), .wthreadid(a_wt), .wchanid(a_wc), .d8(a_d8), .wea(a_wea),
        .web(a_web), .wecsb(a_wecsb), .wemempage(a_wemp), .d12(a_d12), .pselw(a_pselw),
        .wep(a_wep), .incp(a_incp), .incsel(a_incsel), .dpc(a_dpc), .wepc(a_wepc),
        .init_busy(a_busy));

    regs_mt #(.THREADS(8), .CHANS(4), .DW(16), .AW(16), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .rthreadid(b_rt), .rchanid(b_rc), .psel0(b_ps0), .psel1(b_ps1),
        .qa(b_qa), .qb(b_qb), .qp0(b_qp0), .qp1(b_qp1), .qpc(b_qpc), .qcsb(b_qcsb),
        .qmempage(b_qmp), .wthreadid(b_wt), .wchanid(b_wc), .d8(b_d8), .wea(b_wea),
        .web(b_web), .wecsb(b_wecsb), .wemempage(b_wemp), .d12(b_d12), .pselw(b_pselw),
        .wep(b_wep), .incp(b_incp), .incsel(b_incsel), .dpc(b_dpc), .wepc(b_wepc),
        .init_busy(b_busy));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic sb_push(input string name, input logic [31:0] exp);
        sb_t r;
        r.name = name;
        r.exp  = exp;
        sb_q.push_back(r);
    endtask

    task automatic sb_pop(input logic [31:0] act);
        sb_t r;
        if (sb_q.size() == 0) begin
            n_checks++;
            $display("FAIL sb_empty: got 0x%0h expected a queued entry", act);
        end else begin
            r = sb_q.pop_front();
            chk(r.name, act, r.exp);
        end
    endtask

    task automatic a_idle();
        a_wea = 1'b0; a_web = 1'b0; a_wecsb = 1'b0; a_wemp = 1'b0;
        a_wep = 1'b0; a_incp = 1'b0; a_wepc = 1'b0;
    endtask

    task automatic b_idle();
        b_wea = 1'b0; b_web = 1'b0; b_wecsb = 1'b0; b_wemp = 1'b0;
        b_wep = 1'b0; b_incp = 1'b0; b_wepc = 1'b0;
    endtask

    // Called right after rst drops: counts busy cycles while trying a write that must be dropped.
    task automatic measure_clear(input string tag);
        int ca, cb;
        bit a_done, b_done;
        ca = 0; cb = 0; a_done = 1'b0; b_done = 1'b0;
        a_wt = 5'd0; a_d8 = 8'h77; a_wea = 1'b1;
        b_wt = 3'd0; b_d8 = 16'h7777; b_wea = 1'b1;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (a_busy && !a_done) ca++; else a_done = 1'b1;
            if (b_busy && !b_done) cb++; else b_done = 1'b1;
            if (i == 6)  b_wea = 1'b0;
            if (i == 30) a_wea = 1'b0;
            @(negedge clk);
        end
        chk({tag, "_a_len"}, 32'(ca), 32'd32);
        chk({tag, "_b_len"}, 32'(cb), 32'd8);
    endtask

    task automatic zero_scan(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            a_rt = 5'(i); a_rc = 4'(i); a_ps0 = 2'd0; a_ps1 = 2'd1;
            b_rt = 3'(i); b_rc = 2'(i); b_ps0 = 2'd0; b_ps1 = 2'd1;
            #1;
            if ((|a_qa) || (|a_qb) || (|a_qpc) || (|a_qp0) || (|a_qp1)) bad++;
            if (i < 8 && ((|b_qa) || (|b_qb) || (|b_qpc) || (|b_qp0) || (|b_qp1))) bad++;
            a_ps0 = 2'd2; a_ps1 = 2'd3; b_ps0 = 2'd2; b_ps1 = 2'd3;
            #1;
            if (i < 16 && ((|a_qcsb) || (|a_qmp) || (|a_qp0) || (|a_qp1))) bad++;
            if (i < 4 && ((|b_qcsb) || (|b_qmp) || (|b_qp0) || (|b_qp1))) bad++;
        end
        chk({tag, "_nonzero_locs"}, 32'(bad), 32'd0);
    endtask

    initial begin
        vecs[0] = '{5'd5,  5'd5,  1'b1, 1'b0, 8'hA5, 8'hA5, 8'h00};
        vecs[1] = '{5'd5,  5'd5,  1'b0, 1'b1, 8'h3C, 8'hA5, 8'h3C};
        vecs[2] = '{5'd6,  5'd5,  1'b1, 1'b1, 8'h11, 8'hA5, 8'h3C};
        vecs[3] = '{5'd6,  5'd6,  1'b1, 1'b0, 8'h22, 8'h22, 8'h11};
        vecs[4] = '{5'd0,  5'd0,  1'b1, 1'b1, 8'hFF, 8'hFF, 8'hFF};
        vecs[5] = '{5'd31, 5'd31, 1'b0, 1'b1, 8'h80, 8'h00, 8'h80};
        vecs[6] = '{5'd1,  5'd6,  1'b0, 1'b0, 8'h00, 8'h22, 8'h11};

        rst = 1'b1;
        a_idle(); b_idle();
        a_rt = 5'd0; a_rc = 4'd0; a_ps0 = 2'd0; a_ps1 = 2'd0; a_wt = 5'd0; a_wc = 4'd0;
        a_d8 = 8'h00; a_d12 = 12'h000; a_pselw = 2'd0; a_incsel = 2'd0; a_dpc = 12'h000;
        b_rt = 3'd0; b_rc = 2'd0; b_ps0 = 2'd0; b_ps1 = 2'd0; b_wt = 3'd0; b_wc = 2'd0;
        b_d8 = 16'h0; b_d12 = 16'h0; b_pselw = 2'd0; b_incsel = 2'd0; b_dpc = 16'h0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_a_busy", 32'(a_busy), 32'd1);
        chk("rst_b_busy", 32'(b_busy), 32'd1);
        chk("rst_a_qa", 32'(a_qa), 32'd0);
        chk("rst_a_qpc", 32'(a_qpc), 32'd0);
        chk("rst_b_qa", 32'(b_qa), 32'd0);

        @(negedge clk);
        rst = 1'b0;
        measure_clear("clr1");
        zero_scan("clr1");

        // Table: A/B writes with same-cycle forwarding on instance A
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            a_idle();
            a_wt = vecs[i].wt; a_rt = vecs[i].rt; a_d8 = vecs[i].d8;
            a_wea = vecs[i].wea; a_web = vecs[i].web;
            sb_push($sformatf("vec%0d_qa", i), 32'(vecs[i].eqa));
            sb_push($sformatf("vec%0d_qb", i), 32'(vecs[i].eqb));
            #2;
            sb_pop(32'(a_qa));
            sb_pop(32'(a_qb));
        end
        @(negedge clk);
        a_idle(); a_rt = 5'd5;
        sb_push("stored_qa5", 32'h0A5); sb_push("stored_qb5", 32'h03C);
        #2; sb_pop(32'(a_qa)); sb_pop(32'(a_qb));

        // P2 wrap on increment, P0 untouched
        @(negedge clk); a_idle(); a_wep = 1'b1; a_pselw = 2'd2; a_wc = 4'd3; a_d12 = 12'hFFF;
        @(negedge clk); a_idle(); a_wep = 1'b1; a_pselw = 2'd0; a_wt = 5'd3; a_d12 = 12'h055;
        @(negedge clk); a_idle(); a_incp = 1'b1; a_incsel = 2'd2; a_wc = 4'd3; a_wt = 5'd3;
        a_rc = 4'd3; a_ps0 = 2'd2; a_rt = 5'd3; a_ps1 = 2'd0;
        sb_push("inc_wrap_fwd", 32'h000);
        #2; sb_pop(32'(a_qp0));
        @(negedge clk); a_idle();
        sb_push("inc_wrap", 32'h000); sb_push("p0_unchanged", 32'h055);
        #2; sb_pop(32'(a_qp0)); sb_pop(32'(a_qp1));

        // wep and incp on the same pointer: write wins
        @(negedge clk); a_idle(); a_wep = 1'b1; a_pselw = 2'd1; a_wt = 5'd7; a_d12 = 12'h010;
        @(negedge clk); a_idle(); a_wep = 1'b1; a_pselw = 2'd1; a_d12 = 12'h123;
        a_incp = 1'b1; a_incsel = 2'd1; a_rt = 5'd7; a_ps0 = 2'd1;
        sb_push("wep_wins_fwd", 32'h123);
        #2; sb_pop(32'(a_qp0));
        @(negedge clk); a_idle();
        sb_push("wep_wins", 32'h123);
        #2; sb_pop(32'(a_qp0));

        // wep and incp on different pointers: both happen
        @(negedge clk); a_idle(); a_wep = 1'b1; a_pselw = 2'd1; a_d12 = 12'h010;
        @(negedge clk); a_idle(); a_wep = 1'b1; a_pselw = 2'd0; a_d12 = 12'h0AB;
        @(negedge clk); a_idle(); a_wep = 1'b1; a_pselw = 2'd1; a_d12 = 12'h123;
        a_incp = 1'b1; a_incsel = 2'd0;
        @(negedge clk); a_idle(); a_ps0 = 2'd0; a_ps1 = 2'd1;
        sb_push("both_p0_inc", 32'h0AC); sb_push("both_p1_wr", 32'h123);
        #2; sb_pop(32'(a_qp0)); sb_pop(32'(a_qp1));

        // Instance B without forwarding
        @(negedge clk); b_idle(); b_wea = 1'b1; b_wt = 3'd5; b_d8 = 16'h00A5; b_rt = 3'd5;
        sb_push("nobyp_same", 32'h0);
        #2; sb_pop(32'(b_qa));
        @(negedge clk); b_idle();
        sb_push("nobyp_next", 32'h0A5);
        #2; sb_pop(32'(b_qa));

        // Instance B: every enable in one cycle
        @(negedge clk); b_idle();
        b_wt = 3'd2; b_wc = 2'd1; b_d8 = 16'h1234;
        b_wea = 1'b1; b_web = 1'b1; b_wecsb = 1'b1; b_wemp = 1'b1;
        b_wep = 1'b1; b_pselw = 2'd3; b_d12 = 16'hBEEF;
        b_incp = 1'b1; b_incsel = 2'd0; b_wepc = 1'b1; b_dpc = 16'hCAFE;
        @(negedge clk); b_idle(); b_rt = 3'd2; b_rc = 2'd1; b_ps0 = 2'd3; b_ps1 = 2'd0;
        sb_push("all_qa", 32'h1234); sb_push("all_qb", 32'h1234);
        sb_push("all_qcsb", 32'h1234); sb_push("all_qmp", 32'h1234);
        sb_push("all_qpc", 32'hCAFE); sb_push("all_p3", 32'hBEEF); sb_push("all_p0inc", 32'h1);
        #2;
        sb_pop(32'(b_qa)); sb_pop(32'(b_qb)); sb_pop(32'(b_qcsb)); sb_pop(32'(b_qmp));
        sb_pop(32'(b_qpc)); sb_pop(32'(b_qp0)); sb_pop(32'(b_qp1));
        b_ps0 = 2'd1; b_ps1 = 2'd2;
        sb_push("all_p1_untouched", 32'h0); sb_push("all_p2_untouched", 32'h0);
        #1; sb_pop(32'(b_qp0)); sb_pop(32'(b_qp1));

        // Traffic everywhere, then reset in the middle of it
        for (int t = 0; t < 32; t++) begin
            @(negedge clk);
            a_wt = 5'(t); a_wc = 4'(t); a_d8 = 8'(t + 1); a_dpc = 12'(t + 1);
            a_d12 = 12'(t + 256); a_pselw = 2'(t); a_incsel = 2'(t + 1);
            a_wea = 1'b1; a_web = 1'b1; a_wecsb = 1'b1; a_wemp = 1'b1;
            a_wep = 1'b1; a_incp = 1'b1; a_wepc = 1'b1;
            b_wt = 3'(t); b_wc = 2'(t); b_d8 = 16'(t + 1); b_dpc = 16'(t + 1);
            b_d12 = 16'(t + 256); b_pselw = 2'(t); b_incsel = 2'(t + 1);
            b_wea = 1'b1; b_web = 1'b1; b_wecsb = 1'b1; b_wemp = 1'b1;
            b_wep = 1'b1; b_incp = 1'b1; b_wepc = 1'b1;
        end
        @(negedge clk);
        rst = 1'b1;
        #2;
        chk("mid_rst_a_busy", 32'(a_busy), 32'd1);
        chk("mid_rst_b_busy", 32'(b_busy), 32'd1);
        chk("mid_rst_a_qa", 32'(a_qa), 32'd0);
        repeat (3) @(negedge clk);
        a_idle(); b_idle();
        rst = 1'b0;
        measure_clear("clr2");
        zero_scan("clr2");

        if (sb_q.size() != 0) begin
            n_checks++;
            $display("FAIL sb_leftover: got %0d entries expected 0", sb_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
